// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcode, state, class and mux encodings for the sequenced control unit
package cu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SW   = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_MOVA = 4'b0110;
    localparam logic [3:0] OP_LDA  = 4'b1011;
    localparam logic [3:0] OP_NOP  = 4'b1100;
    localparam logic [3:0] OP_J    = 4'b1101;
    localparam logic [3:0] OP_JZ   = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [2:0] U7_NONE = 3'b000;
    localparam logic [2:0] U7_ACC  = 3'b010;
    localparam logic [2:0] U7_MBR  = 3'b011;

    localparam logic U8_MBR = 1'b0;
    localparam logic U8_ALU = 1'b1;

    localparam logic [1:0] U9_IDLE = 2'b00;
    localparam logic [1:0] U9_PC   = 2'b01;
    localparam logic [1:0] U9_MAR  = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_MADDR, ST_MEM, ST_WB, ST_EXEC, ST_JUMP, ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU, CL_MOVA, CL_LW, CL_LDA, CL_SW, CL_NOP, CL_J, CL_JZ, CL_HALT, CL_ILL
    } class_e;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode classifier with ALU select and illegal detection
module cu_decode
    import cu_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int NREG = 4,
    parameter int RSW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic [OPW-1:0] opcode,
    input  logic [RSW-1:0] rd_sel,
    output class_e         op_class,
    output logic [1:0]     alu_sel,
    output logic           illegal
);

    logic [3:0] op_lo;
    assign op_lo = opcode[3:0];

    // Map the low nibble to a class, then veto anything with upper bits set or an out-of-range register
    always_comb begin
        op_class = CL_ILL;
        alu_sel  = ALU_ADD;
        case (op_lo)
            OP_ADD:  begin op_class = CL_ALU; alu_sel = ALU_ADD; end
            OP_SUB:  begin op_class = CL_ALU; alu_sel = ALU_SUB; end
            OP_AND:  begin op_class = CL_ALU; alu_sel = ALU_AND; end
            OP_OR:   begin op_class = CL_ALU; alu_sel = ALU_OR;  end
            OP_MOVA: op_class = CL_MOVA;
            OP_LW:   op_class = CL_LW;
            OP_LDA:  op_class = CL_LDA;
            OP_SW:   op_class = CL_SW;
            OP_NOP:  op_class = CL_NOP;
            OP_J:    op_class = CL_J;
            OP_JZ:   op_class = CL_JZ;
            OP_HALT: op_class = CL_HALT;
            default: op_class = CL_ILL;
        endcase
        if ((opcode >> 4) != '0 || 32'(rd_sel) >= 32'(NREG)) begin
            op_class = CL_ILL;
        end
        illegal = (op_class == CL_ILL);
    end

endmodule

// File: rtl/cu_seq.sv
// rtl/cu_seq.sv - multi-cycle sequenced control unit driving datapath loads, muxes and memory strobes
module cu_seq
    import cu_pkg::*;
#(
    parameter  int OPW  = 4,
    parameter  int NREG = 4,
    localparam int RSW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic [RSW-1:0]  rd_sel,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [1:0]      alu_sel,
    output logic [2:0]      mux_sel_u7,
    output logic            mux_sel_u8,
    output logic [1:0]      mux_sel_u9,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_mar,
    output logic            load_mbr,
    output logic            load_acc,
    output logic [NREG-1:0] load_reg,
    output logic            read_rom,
    output logic            read_ram,
    output logic            write_ram,
    output logic            illegal,
    output logic            halted
);

    state_e         state_q, state_d;
    class_e         cls_q, cls_d;
    logic [1:0]     alu_q, alu_d;
    logic [RSW-1:0] rd_q, rd_d;
    logic           illegal_q, illegal_d;

    class_e         dec_class;
    logic [1:0]     dec_alu;
    logic           dec_illegal;

    cu_decode #(.OPW(OPW), .NREG(NREG), .RSW(RSW)) u_decode (
        .opcode   (opcode),
        .rd_sel   (rd_sel),
        .op_class (dec_class),
        .alu_sel  (dec_alu),
        .illegal  (dec_illegal)
    );

    assign illegal = illegal_q;

    // State, captured instruction fields and the sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cls_q     <= CL_NOP;
            alu_q     <= ALU_ADD;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_q     <= alu_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and strobe decode; rst gates everything so an in-flight access drops at once
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_d      = alu_q;
        rd_d       = rd_q;
        illegal_d  = illegal_q;
        alu_sel    = ALU_ADD;
        mux_sel_u7 = U7_NONE;
        mux_sel_u8 = U8_MBR;
        mux_sel_u9 = U9_IDLE;
        inc_pc     = 1'b0;
        load_pc    = 1'b0;
        load_ir    = 1'b0;
        load_mar   = 1'b0;
        load_mbr   = 1'b0;
        load_acc   = 1'b0;
        load_reg   = '0;
        read_rom   = 1'b0;
        read_ram   = 1'b0;
        write_ram  = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    read_rom   = 1'b1;
                    mux_sel_u9 = U9_PC;
                    if (mem_ready) begin
                        load_ir = 1'b1;
                        inc_pc  = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    cls_d = dec_class;
                    alu_d = dec_alu;
                    rd_d  = rd_sel;
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        case (dec_class)
                            CL_ALU, CL_MOVA:     state_d = ST_EXEC;
                            CL_LW, CL_LDA, CL_SW: state_d = ST_MADDR;
                            CL_J, CL_JZ:         state_d = ST_JUMP;
                            CL_HALT:             state_d = ST_HALT;
                            default:             state_d = ST_FETCH;
                        endcase
                    end
                end
                ST_MADDR: begin
                    load_mar = 1'b1;
                    state_d  = ST_MEM;
                end
                ST_MEM: begin
                    mux_sel_u9 = U9_MAR;
                    if (cls_q == CL_SW) begin
                        write_ram = 1'b1;
                    end else begin
                        read_ram = 1'b1;
                    end
                    if (mem_ready) begin
                        if (cls_q == CL_SW) begin
                            state_d = ST_FETCH;
                        end else begin
                            load_mbr = 1'b1;
                            state_d  = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (cls_q == CL_LW) begin
                        load_reg   = NREG'(1) << rd_q;
                        mux_sel_u7 = U7_MBR;
                    end else begin
                        load_acc   = 1'b1;
                        mux_sel_u8 = U8_MBR;
                    end
                    state_d = ST_FETCH;
                end
                ST_EXEC: begin
                    if (cls_q == CL_MOVA) begin
                        load_reg   = NREG'(1) << rd_q;
                        mux_sel_u7 = U7_ACC;
                    end else begin
                        load_acc   = 1'b1;
                        mux_sel_u8 = U8_ALU;
                        alu_sel    = alu_q;
                    end
                    state_d = ST_FETCH;
                end
                ST_JUMP: begin
                    load_pc = (cls_q == CL_J) || zero;
                    state_d = ST_FETCH;
                end
                ST_HALT: halted = 1'b1;
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule
